// File: rtl/univ_shift_register_if.sv
// Handshake and data bundle for univ_shift_register: the controller drives the
// master side, the register sits on the slave side.
interface univ_shift_register_if #(
    parameter int N  = 10,
    parameter int AW = 4
);
    logic          load;
    logic [N-1:0]  data_in;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic          ser_in;
    logic [N-1:0]  parout;
    logic          ser_out;
    logic          carry;
    logic          zero;
    logic          busy;
    logic          done;

    modport master (
        output load, data_in, start, op, amt, ser_in,
        input  parout, ser_out, carry, zero, busy, done
    );

    modport slave (
        input  load, data_in, start, op, amt, ser_in,
        output parout, ser_out, carry, zero, busy, done
    );
endinterface

// File: rtl/univ_shift_register.sv
// Universal datapath register: parallel load, bit-serial shift/rotate, INC/DEC,
// with start/busy/done handshake. Define USR_SERIN_EN to fill SHL/SHR from ser_in.
module univ_shift_register #(
    parameter int N  = 10,
    parameter int AW = 4
) (
    input  logic                  clk,
    input  logic                  sclr,
    univ_shift_register_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_SHL = 3'b000,
        OP_SHR = 3'b001,
        OP_SAR = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100,
        OP_INC = 3'b101,
        OP_DEC = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    state_t        state;
    op_t           op_q;
    op_t           op_in;
    logic [AW-1:0] cnt;
    logic [N-1:0]  reg_q;
    logic          ser_out_q;
    logic          carry_q;
    logic          busy_q;
    logic          done_q;

    logic [N-1:0]  step_val;
    logic          step_out;
    logic          fill;
    logic [N:0]    inc_sum;
    logic [N:0]    dec_diff;

`ifdef USR_SERIN_EN
    assign fill = bus.ser_in;
`else
    assign fill = 1'b0;
`endif

    assign op_in    = op_t'(bus.op);
    // The extra top bit is the carry (INC) or borrow (DEC) of the N-bit operation.
    assign inc_sum  = {1'b0, reg_q} + (N+1)'(1);
    assign dec_diff = {1'b0, reg_q} - (N+1)'(1);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        step_val = reg_q;
        step_out = ser_out_q;
        case (op_q)
            OP_SHL: begin
                step_val = {reg_q[N-2:0], fill};
                step_out = reg_q[N-1];
            end
            OP_SHR: begin
                step_val = {fill, reg_q[N-1:1]};
                step_out = reg_q[0];
            end
            OP_SAR: begin
                step_val = {reg_q[N-1], reg_q[N-1:1]};
                step_out = reg_q[0];
            end
            OP_ROL: begin
                step_val = {reg_q[N-2:0], reg_q[N-1]};
                step_out = reg_q[N-1];
            end
            OP_ROR: begin
                step_val = {reg_q[0], reg_q[N-1:1]};
                step_out = reg_q[0];
            end
            default: ;
        endcase
    end

    // NOTE: all state updates below are non-blocking so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state     <= IDLE;
            op_q      <= OP_NOP;
            cnt       <= '0;
            reg_q     <= '0;
            ser_out_q <= 1'b0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        reg_q <= bus.data_in;
                    end else if (bus.start) begin
                        case (op_in)
                            OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
                                op_q <= op_in;
                                cnt  <= bus.amt;
                                if (bus.amt == '0) begin
                                    state  <= FIN;
                                    done_q <= 1'b1;
                                end else begin
                                    state  <= SHIFT;
                                    busy_q <= 1'b1;
                                end
                            end
                            OP_INC: begin
                                {carry_q, reg_q} <= inc_sum;
                                state            <= FIN;
                                done_q           <= 1'b1;
                            end
                            OP_DEC: begin
                                {carry_q, reg_q} <= dec_diff;
                                state            <= FIN;
                                done_q           <= 1'b1;
                            end
                            default: begin
                                state  <= FIN;
                                done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    reg_q     <= step_val;
                    ser_out_q <= step_out;
                    cnt       <= cnt - AW'(1);
                    // Last step: leave SHIFT with done already registered.
                    if (cnt == AW'(1)) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.parout  = reg_q;
    assign bus.ser_out = ser_out_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = (reg_q == '0);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
